// File: rtl/anabellek_hakem.sv
// Round-robin arbiter sharing one main-memory port between two cache controllers.
// Latency: grant same cycle as request in BOSTA, memory request next cycle, read data passed through combinationally.
// Backpressure: losing port holds its request; memory request held until accepted; owner ready steers response ready.
module anabellek_hakem #(
    parameter int ADRES_W = 32,
    parameter int VERI_W  = 128,
    parameter int SAYAC_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,

    input  logic [ADRES_W-1:0] onb0_istek_adres_i,
    input  logic [VERI_W-1:0]  onb0_istek_veri_i,
    input  logic               onb0_istek_gecerli_i,
    input  logic               onb0_istek_yaz_gecerli_i,
    output logic               onb0_istek_hazir_o,
    output logic [VERI_W-1:0]  onb0_cevap_veri_o,
    output logic               onb0_cevap_gecerli_o,
    input  logic               onb0_cevap_hazir_i,

    input  logic [ADRES_W-1:0] onb1_istek_adres_i,
    input  logic [VERI_W-1:0]  onb1_istek_veri_i,
    input  logic               onb1_istek_gecerli_i,
    input  logic               onb1_istek_yaz_gecerli_i,
    output logic               onb1_istek_hazir_o,
    output logic [VERI_W-1:0]  onb1_cevap_veri_o,
    output logic               onb1_cevap_gecerli_o,
    input  logic               onb1_cevap_hazir_i,

    output logic [ADRES_W-1:0] anabellek_istek_adres_o,
    output logic [VERI_W-1:0]  anabellek_istek_veri_o,
    output logic               anabellek_istek_gecerli_o,
    output logic               anabellek_istek_yaz_gecerli_o,
    input  logic               anabellek_istek_hazir_i,
    input  logic [VERI_W-1:0]  anabellek_cevap_veri_i,
    input  logic               anabellek_cevap_gecerli_i,
    output logic               anabellek_cevap_hazir_o,

    output logic               sahip_o,
    output logic               mesgul_o,
    output logic [SAYAC_W-1:0] islem_sayac0_o,
    output logic [SAYAC_W-1:0] islem_sayac1_o
);

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        ISTEK = 2'd1,
        CEVAP = 2'd2
    } durum_t;

    durum_t               durum_q;
    logic                 sahip_q;
    logic                 oncelik_q;
    logic                 yaz_q;
    logic [ADRES_W-1:0]   adres_q;
    logic [VERI_W-1:0]    veri_q;
    logic [SAYAC_W-1:0]   sayac0_q, sayac1_q;
    logic [SAYAC_W-1:0]   sayac0_d, sayac1_d;

    logic bosta, istek, cevap;
    logic hibe, hibe_sec, sahip_hazir, bitti;

    assign bosta = (durum_q == BOSTA);
    assign istek = (durum_q == ISTEK);
    assign cevap = (durum_q == CEVAP);

    // Grant is gated by reset so no port sees hazir while reset is asserted.
    assign hibe     = rst_ni && bosta && (onb0_istek_gecerli_i || onb1_istek_gecerli_i);
    assign hibe_sec = (onb0_istek_gecerli_i && onb1_istek_gecerli_i) ? oncelik_q : onb1_istek_gecerli_i;

    assign onb0_istek_hazir_o = hibe && !hibe_sec;
    assign onb1_istek_hazir_o = hibe && hibe_sec;

    assign sahip_hazir             = sahip_q ? onb1_cevap_hazir_i : onb0_cevap_hazir_i;
    assign anabellek_cevap_hazir_o = cevap && sahip_hazir;

    assign onb0_cevap_gecerli_o = cevap && !sahip_q && anabellek_cevap_gecerli_i;
    assign onb1_cevap_gecerli_o = cevap && sahip_q && anabellek_cevap_gecerli_i;
    assign onb0_cevap_veri_o    = (cevap && !sahip_q) ? anabellek_cevap_veri_i : '0;
    assign onb1_cevap_veri_o    = (cevap && sahip_q) ? anabellek_cevap_veri_i : '0;

    assign bitti = (istek && anabellek_istek_hazir_i && yaz_q) ||
                   (cevap && anabellek_cevap_gecerli_i && sahip_hazir);

    assign sayac0_d = (sayac0_q == '1) ? sayac0_q : sayac0_q + SAYAC_W'(1);
    assign sayac1_d = (sayac1_q == '1) ? sayac1_q : sayac1_q + SAYAC_W'(1);

    assign anabellek_istek_adres_o       = adres_q;
    assign anabellek_istek_veri_o        = veri_q;
    assign anabellek_istek_gecerli_o     = istek;
    assign anabellek_istek_yaz_gecerli_o = istek && yaz_q;

    assign sahip_o        = sahip_q;
    assign mesgul_o       = !bosta;
    assign islem_sayac0_o = sayac0_q;
    assign islem_sayac1_o = sayac1_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q   <= BOSTA;
            sahip_q   <= 1'b0;
            oncelik_q <= 1'b0;
            yaz_q     <= 1'b0;
            adres_q   <= '0;
            veri_q    <= '0;
            sayac0_q  <= '0;
            sayac1_q  <= '0;
        end else begin
            case (durum_q)
                BOSTA: begin
                    if (hibe) begin
                        sahip_q <= hibe_sec;
                        adres_q <= hibe_sec ? onb1_istek_adres_i : onb0_istek_adres_i;
                        veri_q  <= hibe_sec ? onb1_istek_veri_i : onb0_istek_veri_i;
                        yaz_q   <= hibe_sec ? onb1_istek_yaz_gecerli_i : onb0_istek_yaz_gecerli_i;
                        durum_q <= ISTEK;
                    end
                end
                ISTEK: begin
                    if (anabellek_istek_hazir_i) begin
                        durum_q <= yaz_q ? BOSTA : CEVAP;
                    end
                end
                CEVAP: begin
                    if (anabellek_cevap_gecerli_i && sahip_hazir) begin
                        durum_q <= BOSTA;
                    end
                end
                default: durum_q <= BOSTA;
            endcase

            // Completion hands priority to the other port and bumps the owner's count.
            if (bitti) begin
                oncelik_q <= ~sahip_q;
                if (sahip_q) begin
                    sayac1_q <= sayac1_d;
                end else begin
                    sayac0_q <= sayac0_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_anabellek_hakem.sv
// Bench for anabellek_hakem: transaction-level model of round-robin grants and saturating counts.
module tb_anabellek_hakem;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  a0 = '0, a1 = '0;
    logic [127:0] d0 = '0, d1 = '0;
    logic         v0 = 1'b0, v1 = 1'b0, w0 = 1'b0, w1 = 1'b0;
    logic         h0, h1;
    logic [127:0] cd0, cd1;
    logic         cv0, cv1;
    logic         cr0 = 1'b0, cr1 = 1'b0;
    logic [31:0]  m_adr;
    logic [127:0] m_dat;
    logic         m_vld, m_wr;
    logic         m_rdy = 1'b0;
    logic [127:0] m_rsp = '0;
    logic         m_rsp_vld = 1'b0;
    logic         m_rsp_rdy;
    logic         sahip, mesgul;
    logic [1:0]   s0, s1;

    int n_vec = 0;
    int n_err = 0;
    int m_prio;
    int m_cnt[2];

    always #5 clk = ~clk;

    anabellek_hakem #(.ADRES_W(32), .VERI_W(128), .SAYAC_W(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .onb0_istek_adres_i(a0), .onb0_istek_veri_i(d0), .onb0_istek_gecerli_i(v0),
        .onb0_istek_yaz_gecerli_i(w0), .onb0_istek_hazir_o(h0), .onb0_cevap_veri_o(cd0),
        .onb0_cevap_gecerli_o(cv0), .onb0_cevap_hazir_i(cr0),
        .onb1_istek_adres_i(a1), .onb1_istek_veri_i(d1), .onb1_istek_gecerli_i(v1),
        .onb1_istek_yaz_gecerli_i(w1), .onb1_istek_hazir_o(h1), .onb1_cevap_veri_o(cd1),
        .onb1_cevap_gecerli_o(cv1), .onb1_cevap_hazir_i(cr1),
        .anabellek_istek_adres_o(m_adr), .anabellek_istek_veri_o(m_dat),
        .anabellek_istek_gecerli_o(m_vld), .anabellek_istek_yaz_gecerli_o(m_wr),
        .anabellek_istek_hazir_i(m_rdy), .anabellek_cevap_veri_i(m_rsp),
        .anabellek_cevap_gecerli_i(m_rsp_vld), .anabellek_cevap_hazir_o(m_rsp_rdy),
        .sahip_o(sahip), .mesgul_o(mesgul),
        .islem_sayac0_o(s0), .islem_sayac1_o(s1)
    );

    function automatic int model_pick(input logic rq0, input logic rq1);
        if (rq0 && rq1) return m_prio;
        return rq1 ? 1 : 0;
    endfunction

    function automatic void model_done(input int g);
        m_prio = 1 - g;
        if (m_cnt[g] < 3) m_cnt[g] = m_cnt[g] + 1;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0; v0 = 0; v1 = 0; m_rdy = 0; m_rsp_vld = 0; cr0 = 0; cr1 = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_prio = 0; m_cnt[0] = 0; m_cnt[1] = 0;
    endtask

    // Drives one transaction end to end as cache ports plus memory; reports what it observed.
    task automatic do_txn(input logic rq0, input logic rq1, input logic wr0, input logic wr1,
                          input logic [31:0] ad0, input logic [31:0] ad1,
                          input logic [127:0] dt0, input logic [127:0] dt1,
                          input int mem_lat, input int rdy_lat, input logic [127:0] rsp,
                          output int gport, output int gwait, output logic [31:0] o_adr,
                          output logic [127:0] o_dat, output logic o_wr, output logic [127:0] o_rsp,
                          output int anomalies, output logic tout);
        logic wrx;
        anomalies = 0; tout = 0; gport = -1; gwait = 0; o_rsp = '0;
        o_adr = '0; o_dat = '0; o_wr = 0;
        v0 = rq0; w0 = wr0; a0 = ad0; d0 = dt0;
        v1 = rq1; w1 = wr1; a1 = ad1; d1 = dt1;
        forever begin
            #1;
            if (h0 || h1) break;
            gwait++;
            if (gwait > 20) begin
                tout = 1; v0 = 0; v1 = 0;
                return;
            end
            @(posedge clk); #1;
        end
        if (h0 && h1) anomalies++;
        if (mesgul !== 1'b0) anomalies++;
        gport = h1 ? 1 : 0;
        wrx = gport ? wr1 : wr0;
        @(posedge clk); #1;
        if (gport == 0) begin v0 = 0; a0 = ~ad0; d0 = ~dt0; w0 = ~wr0; end
        else begin v1 = 0; a1 = ~ad1; d1 = ~dt1; w1 = ~wr1; end
        for (int i = 0; i <= mem_lat; i++) begin
            m_rdy = (i == mem_lat);
            #1;
            if (i == 0) begin
                o_adr = m_adr; o_dat = m_dat; o_wr = m_wr;
            end else if (m_adr !== o_adr || m_dat !== o_dat || m_wr !== o_wr) begin
                anomalies++;
            end
            if (m_vld !== 1'b1 || sahip !== gport[0] || h0 || h1 || m_rsp_rdy !== 1'b0 || mesgul !== 1'b1)
                anomalies++;
            @(posedge clk); #1;
        end
        m_rdy = 0;
        if (!wrx) begin
            m_rsp_vld = 1; m_rsp = rsp;
            for (int i = 0; i <= rdy_lat; i++) begin
                if (gport == 0) begin cr0 = (i == rdy_lat); cr1 = 1; end
                else begin cr1 = (i == rdy_lat); cr0 = 1; end
                #1;
                if (gport == 0) begin
                    if (cv0 !== 1'b1 || cd0 !== rsp || cv1 !== 1'b0 || cd1 !== '0 || m_rsp_rdy !== cr0) anomalies++;
                    if (i == rdy_lat) o_rsp = cd0;
                end else begin
                    if (cv1 !== 1'b1 || cd1 !== rsp || cv0 !== 1'b0 || cd0 !== '0 || m_rsp_rdy !== cr1) anomalies++;
                    if (i == rdy_lat) o_rsp = cd1;
                end
                if (m_vld !== 1'b0 || h0 || h1) anomalies++;
                @(posedge clk); #1;
            end
            m_rsp_vld = 0; cr0 = 0; cr1 = 0;
        end
        #1;
        if (mesgul !== 1'b0 || m_vld !== 1'b0 || cv0 !== 1'b0 || cv1 !== 1'b0) anomalies++;
    endtask

    int g, gw, an;
    logic [31:0] oa;
    logic [127:0] od, orsp;
    logic ow, to;

    task automatic test_reset();
        #1;
        n_vec++;
        if ({h0, h1, cv0, cv1, cd0, cd1, m_adr, m_dat, m_vld, m_wr, m_rsp_rdy, sahip, mesgul, s0, s1} !== '0) begin
            n_err++; $display("FAIL reset_por: outputs not all zero, got h0=%b h1=%b mesgul=%b m_vld=%b", h0, h1, mesgul, m_vld);
        end
        v0 = 1; w0 = 0; a0 = 32'h0000_0500; d0 = '0;
        #1;
        n_vec++;
        if (h0 !== 1'b0) begin n_err++; $display("FAIL reset_hazir: got %b want 0", h0); end
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        n_vec++;
        if (m_vld !== 1'b1 || m_adr !== 32'h0000_0500) begin
            n_err++; $display("FAIL reset_pre_istek: m_vld=%b adr=%h want 1/00000500", m_vld, m_adr);
        end
        v0 = 0;
        rst_n = 0;
        #1;
        n_vec++;
        if ({h0, h1, cv0, cv1, cd0, cd1, m_adr, m_dat, m_vld, m_wr, m_rsp_rdy, sahip, mesgul, s0, s1} !== '0) begin
            n_err++; $display("FAIL reset_mid_istek: outputs not zero, mesgul=%b m_vld=%b adr=%h", mesgul, m_vld, m_adr);
        end
        @(posedge clk); #1 rst_n = 1;
        m_prio = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        m_rsp_vld = 1; m_rsp = {4{32'hDEAD_BEEF}}; cr0 = 1; cr1 = 1;
        #1;
        n_vec++;
        if ({cv0, cv1, m_rsp_rdy, mesgul} !== 4'b0) begin
            n_err++; $display("FAIL reset_stray_rsp: got %b want 0000", {cv0, cv1, m_rsp_rdy, mesgul});
        end
        @(posedge clk); #1;
        m_rsp_vld = 0; cr0 = 0; cr1 = 0;
        do_txn(1, 1, 0, 0, 32'h0000_1230, 32'h0000_2000, '0, '0, 0, 0, {4{32'h0BAD_F00D}},
               g, gw, oa, od, ow, orsp, an, to);
        v1 = 0;
        n_vec++;
        if (to || g != model_pick(1, 1) || oa !== 32'h0000_1230 || an != 0) begin
            n_err++; $display("FAIL reset_first_grant: port=%0d adr=%h anom=%0d want port 0 adr 00001230", g, oa, an);
        end
        model_done(0);
    endtask

    task automatic test_single_read();
        logic [127:0] rsp;
        rsp = {4{32'hAAAA_AAAA}};
        apply_reset();
        do_txn(0, 1, 0, 0, '0, 32'h0000_0040, '0, '0, 2, 0, rsp, g, gw, oa, od, ow, orsp, an, to);
        n_vec++;
        if (to || g != 1 || gw != 0) begin n_err++; $display("FAIL read_grant: port=%0d wait=%0d want 1/0", g, gw); end
        n_vec++;
        if (oa !== 32'h0000_0040 || ow !== 1'b0) begin n_err++; $display("FAIL read_req: adr=%h wr=%b want 00000040/0", oa, ow); end
        n_vec++;
        if (orsp !== rsp || an != 0) begin n_err++; $display("FAIL read_rsp: data=%h anom=%0d want %h/0", orsp, an, rsp); end
        model_done(1);
        n_vec++;
        if (s1 !== 2'(m_cnt[1]) || s0 !== 2'(m_cnt[0])) begin
            n_err++; $display("FAIL read_count: s0=%0d s1=%0d want %0d %0d", s0, s1, m_cnt[0], m_cnt[1]);
        end
    endtask

    task automatic test_conflict();
        int exp;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            exp = model_pick(1, 1);
            do_txn(1, 1, k[0], ~k[0], 32'h0000_3000 + 32'(k * 16), 32'h0000_4000 + 32'(k * 16),
                   '0, '0, 0, 0, 128'(k), g, gw, oa, od, ow, orsp, an, to);
            n_vec++;
            if (to || g != exp || gw != 0 || an != 0) begin
                n_err++; $display("FAIL conflict_%0d: port=%0d wait=%0d anom=%0d want port %0d", k, g, gw, an, exp);
            end
            model_done(exp);
        end
        v0 = 0; v1 = 0;
    endtask

    task automatic test_write();
        apply_reset();
        do_txn(1, 0, 1, 0, 32'h0000_0100, '0, 128'h1234, '0, 0, 0, '0, g, gw, oa, od, ow, orsp, an, to);
        n_vec++;
        if (to || g != 0 || oa !== 32'h0000_0100 || od !== 128'h1234 || ow !== 1'b1) begin
            n_err++; $display("FAIL write_req: port=%0d adr=%h dat=%h wr=%b want 0/00000100/1234/1", g, oa, od, ow);
        end
        n_vec++;
        if (an != 0) begin n_err++; $display("FAIL write_flow: anomalies=%0d want 0", an); end
        model_done(0);
        n_vec++;
        if (s0 !== 2'(m_cnt[0])) begin n_err++; $display("FAIL write_count: got %0d want %0d", s0, m_cnt[0]); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        do_txn(0, 1, 0, 0, '0, 32'h0000_0880, '0, 128'h55, 5, 3, {4{32'h1357_9BDF}},
               g, gw, oa, od, ow, orsp, an, to);
        n_vec++;
        if (to || an != 0 || orsp !== {4{32'h1357_9BDF}}) begin
            n_err++; $display("FAIL backpressure: anom=%0d data=%h want 0 anomalies", an, orsp);
        end
        model_done(1);
        n_vec++;
        if (s1 !== 2'(m_cnt[1])) begin n_err++; $display("FAIL backpressure_count: got %0d want %0d", s1, m_cnt[1]); end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            do_txn(1, 0, 1, 0, 32'h0000_0200, '0, 128'(k), '0, 0, 0, '0, g, gw, oa, od, ow, orsp, an, to);
            model_done(0);
            n_vec++;
            if (to || s0 !== 2'(m_cnt[0])) begin
                n_err++; $display("FAIL saturate_%0d: got %0d want %0d", k, s0, m_cnt[0]);
            end
        end
    endtask

    task automatic test_random();
        logic rq0, rq1, wr0, wr1;
        logic [31:0] ad0, ad1;
        logic [127:0] dt0, dt1, rsp, exp_dat;
        int exp;
        apply_reset();
        for (int k = 0; k < 30; k++) begin
            rq0 = $urandom_range(0, 1); rq1 = $urandom_range(0, 1);
            if (!rq0 && !rq1) rq0 = 1;
            wr0 = $urandom_range(0, 1); wr1 = $urandom_range(0, 1);
            ad0 = $urandom & 32'hFFFF_FFF0; ad1 = $urandom & 32'hFFFF_FFF0;
            dt0 = {$urandom, $urandom, $urandom, $urandom};
            dt1 = {$urandom, $urandom, $urandom, $urandom};
            rsp = {$urandom, $urandom, $urandom, $urandom};
            exp = model_pick(rq0, rq1);
            do_txn(rq0, rq1, wr0, wr1, ad0, ad1, dt0, dt1, $urandom_range(0, 3), $urandom_range(0, 3), rsp,
                   g, gw, oa, od, ow, orsp, an, to);
            v0 = 0; v1 = 0;
            exp_dat = exp ? dt1 : dt0;
            n_vec++;
            if (to || g != exp || an != 0 || oa !== (exp ? ad1 : ad0) || od !== exp_dat ||
                ow !== (exp ? wr1 : wr0) || (!ow && orsp !== rsp)) begin
                n_err++; $display("FAIL random_%0d: port=%0d adr=%h anom=%0d want port %0d adr %h", k, g, oa, an, exp, exp ? ad1 : ad0);
            end
            model_done(exp);
            n_vec++;
            if (s0 !== 2'(m_cnt[0]) || s1 !== 2'(m_cnt[1])) begin
                n_err++; $display("FAIL random_count_%0d: s0=%0d s1=%0d want %0d %0d", k, s0, s1, m_cnt[0], m_cnt[1]);
            end
        end
    endtask

    initial begin
        m_prio = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        test_reset();
        test_single_read();
        test_conflict();
        test_write();
        test_backpressure();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/anabellek_hakem.md
# anabellek_hakem

Two-port round-robin arbiter that shares one main-memory (anabellek) port between two cache controllers, e.g. instruction and data caches. Each cache-side port uses the same request/response handshake the caches already drive toward main memory; one transaction is in flight at a time. The block sits between the cache controllers and the main-memory model/BRAM bridge, registers each accepted request, and steers the read response back to its owner.

## Interface
- ADRES_W, 32, address width
- VERI_W, 128, block data width (one cache line)
- SAYAC_W, 16, per-port completed-transaction counter width
- clk_i  input  1  clock; all state on rising edge
- rst_ni  input  1  reset; one clock; reset is asynchronous and active-low
- onbN_istek_adres_i  input  ADRES_W  port N (N=0,1) line-aligned request address
- onbN_istek_veri_i  input  VERI_W  port N write data
- onbN_istek_gecerli_i  input  1  port N request valid
- onbN_istek_yaz_gecerli_i  input  1  port N request is a write
- onbN_istek_hazir_o  output  1  port N request accepted this cycle
- onbN_cevap_veri_o  output  VERI_W  port N read data
- onbN_cevap_gecerli_o  output  1  port N read response valid
- onbN_cevap_hazir_i  input  1  port N ready for response
- anabellek_istek_adres_o  output  ADRES_W  memory request address (registered)
- anabellek_istek_veri_o  output  VERI_W  memory write data (registered)
- anabellek_istek_gecerli_o  output  1  memory request valid
- anabellek_istek_yaz_gecerli_o  output  1  memory request is a write
- anabellek_istek_hazir_i  input  1  memory accepts request
- anabellek_cevap_veri_i  input  VERI_W  memory read data
- anabellek_cevap_gecerli_i  input  1  memory read response valid
- anabellek_cevap_hazir_o  output  1  arbiter ready for memory response
- sahip_o  output  1  current/last granted port
- mesgul_o  output  1  high in any state other than BOSTA
- islem_sayac0_o, islem_sayac1_o  output  SAYAC_W  completed transactions per port, saturating

## Operation
- States: BOSTA, ISTEK, CEVAP. Registers: sahip, oncelik (port favoured on conflict), captured adres/veri/yaz, two counters.
- BOSTA: if exactly one port valid, grant it; if both valid, grant port oncelik. Grant = assert onbN_istek_hazir_o combinationally in that cycle, capture adres/veri/yaz, load sahip, go ISTEK. Non-granted port sees hazir_o=0 and must hold its request.
- ISTEK: anabellek_istek_gecerli_o=1, adres/veri/yaz from captured registers, held stable until anabellek_istek_hazir_i=1. On handshake: write -> transaction complete, go BOSTA; read -> go CEVAP.
- CEVAP: anabellek_cevap_hazir_o = onb[sahip]_cevap_hazir_i; onb[sahip]_cevap_gecerli_o = anabellek_cevap_gecerli_i; onb[sahip]_cevap_veri_o = anabellek_cevap_veri_i (combinational pass-through). On both valid and ready high: transaction complete, go BOSTA.
- On transaction complete: oncelik <= ~sahip; islem_sayacN of sahip += 1, saturating at all-ones.
- Non-owner port: cevap_gecerli_o=0, cevap_veri_o=0 always. anabellek_cevap_hazir_o=0 outside CEVAP; stray memory responses in BOSTA/ISTEK are ignored.
- anabellek_istek_* gecerli/yaz = 0 outside ISTEK; adres/veri outputs keep last captured value.

## Timing
- Reset (rst_ni=0, async, any state): state BOSTA, oncelik=0, sahip=0, counters=0, captured regs=0; all outputs 0 within the reset assertion, not waiting for a clock edge. In-flight transaction is dropped; no response is forwarded afterwards.
- Grant latency: hazir_o same cycle as gecerli_i in BOSTA; memory request valid the following cycle.
- Minimum write: 2 cycles (BOSTA grant, ISTEK with immediate hazir). Minimum read: 3 cycles (grant, ISTEK, CEVAP with immediate response and ready). Next grant no earlier than the cycle after return to BOSTA.
- Requests in ISTEK/CEVAP are never accepted (hazir_o=0 for both ports).
- Back-to-back with both ports continuously valid: grants strictly alternate 0,1,0,1...

## Test plan
- Reset: drive rst_ni=0 mid-ISTEK -> all outputs 0 immediately, mesgul_o=0; after release, port0 read to 0x0000_1230 wins first (oncelik=0).
- Single read: port1 read 0x0000_0040, memory hazir after 2 cycles, returns 128'hAAAA...; -> port1 gets cevap_gecerli with that data, port0 cevap_gecerli stays 0, islem_sayac1_o=1.
- Conflict: both ports request in same cycle from reset -> port0 granted, port1 hazir_o=0 and held; after completion port1 granted; repeat both-valid -> port0, port1 alternate.
- Write: port0 write 0x0000_0100 data 128'h1234 -> memory sees yaz_gecerli=1, data matches captured value even if port0 changes inputs after grant; returns to BOSTA without CEVAP.
- Backpressure: memory hazir low 5 cycles, then response with owner cevap_hazir_i low 3 cycles -> request fields stable throughout, anabellek_cevap_hazir_o follows owner ready, single completion counted.
- Saturation: SAYAC_W=2, 5 port0 transactions -> islem_sayac0_o stays 3.
